mrd_sink_wr_ctrl: RTL and testbench
===================================

# mrd_sink_wr_ctrl

Sink-side write controller for the parallel-2 mixed-radix DFT memory. During the FSM `Sink` phase it accepts the input sample stream at two samples per beat, framed by sop/eop/valid. It maps each natural-order sample index n onto the 7-bank RAM as bank = n mod 7 and address = n div 7, then drives per-bank write strobes. On frame completion it pulses `sink_end` to the top FSM; it is the write-side counterpart of the source-phase read/output controller.

## Interface
- DW, 16, width of one real or imaginary component
- AW, 8, bank address width (ceil(1200/7)=172 words)
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- fsm  in  3  top FSM state; Sink = 3'd1
- dftpts  in  12  DFT size; even, 12..1200; sampled at frame sop
- in_valid  in  1  input beat qualifier
- in_sop  in  1  first beat of frame
- in_eop  in  1  last beat of frame
- in_data  in  [0:1][2*DW]  {real,imag}; [0] = sample 2k, [1] = sample 2k+1
- wren  out  [0:6]  per-bank write enable
- wraddr  out  [0:6][AW]  per-bank write address
- wrdata  out  [0:6][2*DW]  per-bank write data
- sink_ongoing  out  1  frame in progress (RECV state)
- sink_end  out  1  one-cycle frame-complete pulse
- err_frame  out  1  one-cycle framing-error pulse

## Operation
- States: IDLE, WAIT_SOP, RECV, DONE.
- IDLE -> WAIT_SOP when fsm==Sink.
- Any state -> IDLE whenever fsm!=Sink. The frame is abandoned, no sink_end is issued, and counters are cleared.
- WAIT_SOP: beats without sop are ignored. valid&sop -> RECV. That beat is beat 1 and latches dftpts[11:1] as the beat target T.
- RECV: every valid beat is written and increments beat count c.
  - Beat with c==T and eop: DONE, sink_end.
  - Beat with c==T and no eop: write it, DONE, sink_end and err_frame.
  - eop with c<T: write it, DONE, sink_end and err_frame.
  - sop in RECV: err_frame. The beat is treated as beat 1 of a new frame: c=1, bank counters restart at sample 0, T is relatched.
- DONE: inputs ignored; hold until fsm leaves Sink.
- Address generation uses no divider.
  - Registers idx (0..6) and baddr (AW) hold the bank and address of sample 2k.
  - Per beat: idx += 2; if the result is ≥7, subtract 7 and increment baddr.
  - Sample 2k+1: bank (idx+1) mod 7; address baddr + (idx==6).
  - Frame start: idx=0, baddr=0.
- The two samples of a beat always hit distinct banks, so at most 2 bits of wren are set per cycle.
- Data in_data[0] goes to bank idx and in_data[1] goes to bank (idx+1) mod 7.
- Non-enabled banks: wraddr and wrdata hold their previous values.
- in_valid=0 beats: no write and no counter change. Gaps of any length are allowed.

## Timing
- One register stage: an input beat at cycle t gives wren/wraddr/wrdata at t+1.
- sink_end and err_frame assert at t+1 of the terminating beat, in the same cycle as its write.
- sink_ongoing is high from t+1 of the sop beat until the cycle sink_end asserts (low in that cycle).
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - wren, sink_end, err_frame, sink_ongoing go to 0.
  - wraddr, wrdata, idx, baddr, c, T go to 0.
- Reset mid-frame discards the frame with no sink_end.
- Throughput: one beat per cycle. No backpressure; the upstream must not send beats outside Sink.
- Beat counter c is 11 bits; T max is 600, so no wrap.

## Test plan
- 12-pt frame, 6 contiguous beats, sample n data = n:
  - Expected sequence: samples 0–6 in banks 0–6 at addr 0; samples 7–11 in banks 0–4 at addr 1.
  - Beat 4 (samples 6,7): wren=1000001b, bank6 addr0 = data 6, bank0 addr1 = data 7.
  - sink_end one cycle after beat 6; err_frame=0.
- 1200-pt frame, 600 beats with random valid gaps:
  - Last beat (samples 1198,1199): bank1 and bank2, both at addr 171.
  - sink_end exactly once; no write to any address >171.
- Early eop on beat 3 of a 24-pt frame:
  - Beat 3 written.
  - sink_end and err_frame together one cycle later.
  - Subsequent beats ignored in DONE.
- sop on beat 4 of a 12-pt frame:
  - err_frame pulses.
  - That beat writes samples 0,1 to banks 0,1 at addr 0.
  - sink_end after 5 more beats.
- fsm leaves Sink at beat 3, then returns:
  - No sink_end.
  - Next sop frame restarts at bank0 addr0.
- rst asserted at beat 2:
  - Outputs go to 0 the next cycle.
  - After release and fsm==Sink, a full 12-pt frame completes normally.

Source files
------------

// File: rtl/mrd_sink_wr_ctrl.sv
// Sink-side write controller for the parallel-2 mixed-radix DFT memory.
// Maps natural-order sample n to bank n mod 7, address n div 7, two samples per beat.
module mrd_sink_wr_ctrl #(
    parameter int DW = 16,
    parameter int AW = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [2:0]                fsm_i,
    input  logic [11:0]               dftpts_i,
    input  logic                      in_valid_i,
    input  logic                      in_sop_i,
    input  logic                      in_eop_i,
    input  logic [0:1][2*DW-1:0]      in_data_i,
    output logic [0:6]                wren_o,
    output logic [0:6][AW-1:0]        wraddr_o,
    output logic [0:6][2*DW-1:0]      wrdata_o,
    output logic                      sink_ongoing_o,
    output logic                      sink_end_o,
    output logic                      err_frame_o
);

    localparam logic [2:0] SINK = 3'd1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SOP,
        RECV,
        DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [2:0]              idx_q, idx_d;
    logic [AW-1:0]           baddr_q, baddr_d;
    logic [10:0]             cnt_q, cnt_d;
    logic [10:0]             tgt_q, tgt_d;
    logic [0:6]              wren_q, wren_d;
    logic [0:6][AW-1:0]      wraddr_q, wraddr_d;
    logic [0:6][2*DW-1:0]    wrdata_q, wrdata_d;
    logic                    end_q, end_d;
    logic                    err_q, err_d;

    logic                    restart;
    logic                    take;
    logic                    last;
    logic                    wrap;
    logic [2:0]              ia, ib;
    logic [AW-1:0]           aa, ab;
    logic [3:0]              isum, iwrap;
    logic [10:0]             beat, tgt;

    // A sop beat always restarts addressing, whether it opens or re-opens a frame.
    assign restart = in_valid_i && in_sop_i &&
                     (state_q == WAIT_SOP || state_q == RECV);
    assign take    = in_valid_i && (restart || state_q == RECV);
    assign ia      = restart ? 3'd0 : idx_q;
    assign aa      = restart ? '0 : baddr_q;
    assign beat    = restart ? 11'd1 : cnt_q + 11'd1;
    assign tgt     = restart ? {1'b0, dftpts_i[11:1]} : tgt_q;
    assign ib      = (ia == 3'd6) ? 3'd0 : ia + 3'd1;
    assign ab      = aa + {{(AW-1){1'b0}}, (ia == 3'd6)};
    assign isum    = {1'b0, ia} + 4'd2;
    assign iwrap   = isum - 4'd7;
    assign wrap    = (isum >= 4'd7);
    assign last    = (beat == tgt);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        baddr_d  = baddr_q;
        cnt_d    = cnt_q;
        tgt_d    = tgt_q;
        wren_d   = '0;
        wraddr_d = wraddr_q;
        wrdata_d = wrdata_q;
        end_d    = 1'b0;
        err_d    = 1'b0;
        if (fsm_i != SINK) begin
            state_d = IDLE;
            idx_d   = '0;
            baddr_d = '0;
            cnt_d   = '0;
            tgt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: state_d = WAIT_SOP;
                WAIT_SOP, RECV: begin
                    if (take) begin
                        wren_d[ia]   = 1'b1;
                        wren_d[ib]   = 1'b1;
                        wraddr_d[ia] = aa;
                        wraddr_d[ib] = ab;
                        wrdata_d[ia] = in_data_i[0];
                        wrdata_d[ib] = in_data_i[1];
                        cnt_d        = beat;
                        tgt_d        = tgt;
                        idx_d        = wrap ? iwrap[2:0] : isum[2:0];
                        baddr_d      = aa + {{(AW-1){1'b0}}, wrap};
                        state_d      = RECV;
                        err_d        = restart && (state_q == RECV);
                        if (last || in_eop_i) begin
                            state_d = DONE;
                            end_d   = 1'b1;
                            if (!(last && in_eop_i)) err_d = 1'b1;
                        end
                    end
                end
                DONE: state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            baddr_q  <= '0;
            cnt_q    <= '0;
            tgt_q    <= '0;
            wren_q   <= '0;
            wraddr_q <= '0;
            wrdata_q <= '0;
            end_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            baddr_q  <= baddr_d;
            cnt_q    <= cnt_d;
            tgt_q    <= tgt_d;
            wren_q   <= wren_d;
            wraddr_q <= wraddr_d;
            wrdata_q <= wrdata_d;
            end_q    <= end_d;
            err_q    <= err_d;
        end
    end

    assign wren_o         = wren_q;
    assign wraddr_o       = wraddr_q;
    assign wrdata_o       = wrdata_q;
    assign sink_end_o     = end_q;
    assign err_frame_o    = err_q;
    assign sink_ongoing_o = (state_q == RECV);

endmodule

// File: tb/tb_mrd_sink_wr_ctrl.sv
// Bench for mrd_sink_wr_ctrl: sample-index reference model checked every
// cycle, plus literal expectations on directed frames.
module tb_mrd_sink_wr_ctrl;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [2:0]        fsm = 3'd0;
    logic [11:0]       dftpts = 12'd12;
    logic              valid = 1'b0;
    logic              sop = 1'b0;
    logic              eop = 1'b0;
    logic [0:1][31:0]  din = '0;
    logic [0:6]        wren;
    logic [0:6][7:0]   wraddr;
    logic [0:6][31:0]  wrdata;
    logic              ongoing, send_o, err;

    int n_cmp = 0;
    int n_bad = 0;
    int n_end = 0;

    mrd_sink_wr_ctrl #(.DW(16), .AW(8)) dut (
        .clk_i(clk), .rst_i(rst), .fsm_i(fsm), .dftpts_i(dftpts),
        .in_valid_i(valid), .in_sop_i(sop), .in_eop_i(eop), .in_data_i(din),
        .wren_o(wren), .wraddr_o(wraddr), .wrdata_o(wrdata),
        .sink_ongoing_o(ongoing), .sink_end_o(send_o), .err_frame_o(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
        end
    endtask

    // Reference model: phase 0 idle, 1 wait sop, 2 receiving, 3 done
    int          ph = 0;
    int          nxt = 0;
    int          cnt = 0;
    int          tgt = 0;
    logic [0:6]  e_wren = '0;
    logic [7:0]  e_addr [7];
    logic [31:0] e_data [7];
    logic        e_end = 1'b0;
    logic        e_err = 1'b0;
    logic        e_ong = 1'b0;

    initial begin
        for (int b = 0; b < 7; b++) begin
            e_addr[b] = '0;
            e_data[b] = '0;
        end
        forever begin
            @(posedge clk);
            e_wren = '0;
            e_end  = 1'b0;
            e_err  = 1'b0;
            if (rst) begin
                ph = 0;
                for (int b = 0; b < 7; b++) begin
                    e_addr[b] = '0;
                    e_data[b] = '0;
                end
            end else if (fsm != 3'd1) begin
                ph = 0;
            end else if (ph == 0) begin
                ph = 1;
            end else if ((ph == 1 || ph == 2) && valid && (sop || ph == 2)) begin
                if (sop) begin
                    e_err = (ph == 2);
                    nxt = 0;
                    cnt = 0;
                    tgt = int'(dftpts) / 2;
                end
                cnt++;
                for (int s = 0; s < 2; s++) begin
                    e_wren[(nxt + s) % 7] = 1'b1;
                    e_addr[(nxt + s) % 7] = 8'((nxt + s) / 7);
                    e_data[(nxt + s) % 7] = din[s];
                end
                nxt += 2;
                ph = 2;
                if (cnt == tgt || eop) begin
                    ph = 3;
                    e_end = 1'b1;
                    if (!(cnt == tgt && eop)) e_err = 1'b1;
                end
            end
            e_ong = (ph == 2);
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (send_o === 1'b1) n_end++;
            chk("wren", 32'(wren), 32'(e_wren));
            chk("sink_end", 32'(send_o), 32'(e_end));
            chk("err_frame", 32'(err), 32'(e_err));
            chk("sink_ongoing", 32'(ongoing), 32'(e_ong));
            for (int b = 0; b < 7; b++) begin
                chk("wraddr", 32'(wraddr[b]), 32'(e_addr[b]));
                chk("wrdata", wrdata[b], e_data[b]);
            end
        end
    end

    function automatic logic [31:0] dat(input int n);
        logic [15:0] lo;
        lo = 16'(3 * n + 1);
        return {16'(n), lo};
    endfunction

    task automatic send(input logic v, input logic s, input logic e,
                        input logic [31:0] d0, input logic [31:0] d1);
        @(negedge clk);
        valid = v;
        sop = s;
        eop = e;
        din[0] = d0;
        din[1] = d1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++)
            send(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom, $urandom);
    endtask

    task automatic pin;
        @(posedge clk);
        #2;
    endtask

    task automatic frame12;
        for (int b = 0; b < 6; b++)
            send(1'b1, b == 0, b == 5, dat(2 * b), dat(2 * b + 1));
    endtask

    int e0;
    logic [31:0] r0, r1;

    initial begin
        pin();
        chk("rst_wren", 32'(wren), 32'd0);
        chk("rst_ongoing", 32'(ongoing), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 12-point contiguous frame
        fsm = 3'd1;
        dftpts = 12'd12;
        e0 = n_end;
        idle(2);
        for (int b = 0; b < 6; b++) begin
            send(1'b1, b == 0, b == 5, dat(2 * b), dat(2 * b + 1));
            if (b == 3) begin
                pin();
                chk("t1_wren", 32'(wren), 32'(7'b1000001));
                chk("t1_addr6", 32'(wraddr[6]), 32'd0);
                chk("t1_data6", wrdata[6], 32'h0006_0013);
                chk("t1_addr0", 32'(wraddr[0]), 32'd1);
                chk("t1_data0", wrdata[0], 32'h0007_0016);
            end
        end
        pin();
        chk("t1_end", 32'(send_o), 32'd1);
        chk("t1_err", 32'(err), 32'd0);
        idle(3);
        chk("t1_ends", 32'(n_end - e0), 32'd1);
        fsm = 3'd0;
        idle(2);

        // 1200-point frame with random gaps
        fsm = 3'd1;
        dftpts = 12'd1200;
        e0 = n_end;
        idle(2);
        for (int b = 0; b < 600; b++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            r0 = $urandom;
            r1 = $urandom;
            send(1'b1, b == 0, b == 599, r0, r1);
        end
        pin();
        chk("t2_wren", 32'(wren), 32'(7'b0110000));
        chk("t2_addr1", 32'(wraddr[1]), 32'd171);
        chk("t2_addr2", 32'(wraddr[2]), 32'd171);
        chk("t2_data1", wrdata[1], r0);
        chk("t2_end", 32'(send_o), 32'd1);
        idle(3);
        chk("t2_ends", 32'(n_end - e0), 32'd1);
        fsm = 3'd0;
        idle(2);

        // 24-point frame with early eop on beat 3
        fsm = 3'd1;
        dftpts = 12'd24;
        e0 = n_end;
        idle(2);
        for (int b = 0; b < 3; b++)
            send(1'b1, b == 0, b == 2, dat(2 * b), dat(2 * b + 1));
        pin();
        chk("t3_end", 32'(send_o), 32'd1);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_wren", 32'(wren), 32'(7'b0000110));
        for (int b = 3; b < 6; b++)
            send(1'b1, 1'b0, 1'b0, dat(2 * b), dat(2 * b + 1));
        idle(2);
        chk("t3_ends", 32'(n_end - e0), 32'd1);
        fsm = 3'd0;
        idle(2);

        // sop on beat 4 of a 12-point frame
        fsm = 3'd1;
        dftpts = 12'd12;
        e0 = n_end;
        idle(2);
        for (int b = 0; b < 3; b++)
            send(1'b1, b == 0, 1'b0, dat(2 * b), dat(2 * b + 1));
        send(1'b1, 1'b1, 1'b0, dat(100), dat(101));
        pin();
        chk("t4_err", 32'(err), 32'd1);
        chk("t4_wren", 32'(wren), 32'(7'b1100000));
        chk("t4_addr0", 32'(wraddr[0]), 32'd0);
        chk("t4_data0", wrdata[0], dat(100));
        for (int b = 1; b < 6; b++)
            send(1'b1, 1'b0, b == 5, dat(2 * b), dat(2 * b + 1));
        pin();
        chk("t4_end", 32'(send_o), 32'd1);
        chk("t4_err2", 32'(err), 32'd0);
        idle(2);
        chk("t4_ends", 32'(n_end - e0), 32'd1);
        fsm = 3'd0;
        idle(2);

        // fsm leaves Sink at beat 3 and returns
        fsm = 3'd1;
        e0 = n_end;
        idle(2);
        send(1'b1, 1'b1, 1'b0, dat(0), dat(1));
        send(1'b1, 1'b0, 1'b0, dat(2), dat(3));
        @(negedge clk);
        valid = 1'b0;
        fsm = 3'd0;
        idle(3);
        chk("t5_noend", 32'(n_end - e0), 32'd0);
        fsm = 3'd1;
        idle(2);
        send(1'b1, 1'b1, 1'b0, dat(0), dat(1));
        pin();
        chk("t5_wren", 32'(wren), 32'(7'b1100000));
        chk("t5_addr0", 32'(wraddr[0]), 32'd0);
        for (int b = 1; b < 6; b++)
            send(1'b1, 1'b0, b == 5, dat(2 * b), dat(2 * b + 1));
        idle(2);
        chk("t5_ends", 32'(n_end - e0), 32'd1);
        fsm = 3'd0;
        idle(2);

        // reset at beat 2, then a normal frame
        fsm = 3'd1;
        idle(2);
        send(1'b1, 1'b1, 1'b0, dat(0), dat(1));
        @(negedge clk);
        rst = 1'b1;
        valid = 1'b1;
        sop = 1'b0;
        din[0] = dat(2);
        din[1] = dat(3);
        pin();
        chk("t6_wren", 32'(wren), 32'd0);
        chk("t6_ongoing", 32'(ongoing), 32'd0);
        chk("t6_data0", wrdata[0], 32'd0);
        chk("t6_end", 32'(send_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        valid = 1'b0;
        e0 = n_end;
        idle(2);
        frame12();
        pin();
        chk("t6_fend", 32'(send_o), 32'd1);
        idle(2);
        chk("t6_ends", 32'(n_end - e0), 32'd1);
        fsm = 3'd0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
